button_decrement_ctrl: RTL

- Front-end stage that drives the countdown display counter's `decrease` input.
- Synchronises and debounces a raw push-button and emits clean, registered, single-cycle decrement pulses.
- Optional auto-repeat while the button is held.
- The downstream counter treats `dec_pulse` as an edge, so the output must be glitch-free and come directly from a flip-flop.

---
 rtl/countdown_pkg.sv | 25 ++
 rtl/sync_2ff.sv | 22 ++
 rtl/button_decrement_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and defaults for the countdown front-end.
// Button FSM encoding plus timing defaults and a width helper.
package countdown_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS_DEB = 3'd1,
        HELD      = 3'd2,
        REPEAT    = 3'd3,
        REL_DEB   = 3'd4
    } btn_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 250000;
    localparam int DEF_HOLD_CYCLES     = 25000000;
    localparam int DEF_REPEAT_CYCLES   = 5000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for one asynchronous input bit.
// Clears to 0 on asynchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_decrement_ctrl.sv
// Debounced push-button to single-cycle decrement strobe,
// with optional auto-repeat while the button is held.
module button_decrement_ctrl
    import countdown_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
    parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
    parameter int CNT_W           =
        $clog2(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn,
    input  logic       en,
    input  logic       repeat_en,
    output logic       dec_pulse,
    output logic       pressed,
    output logic [2:0] state_o
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic             btn_s;
    btn_state_t       state;
    btn_state_t       state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             pulse_nx;
    logic             pressed_nx;
    logic             restart;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn),
        .q     (btn_s)
    );

    always_comb begin
        state_nx = state;
        pulse_nx = 1'b0;
        restart  = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) state_nx = PRESS_DEB;
            end
            PRESS_DEB: begin
                if (!btn_s) begin
                    state_nx = IDLE;
                end else if (cnt == DEB_LAST) begin
                    state_nx = HELD;
                    pulse_nx = 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_nx = REL_DEB;
                end else if (repeat_en && cnt == HOLD_LAST) begin
                    state_nx = REPEAT;
                    pulse_nx = 1'b1;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_nx = REL_DEB;
                end else if (repeat_en && cnt == REP_LAST) begin
                    pulse_nx = 1'b1;
                    restart  = 1'b1;
                end
            end
            REL_DEB: begin
                // A bounce back to 1 re-enters HELD without a second pulse
                if (btn_s) begin
                    state_nx = HELD;
                end else if (cnt == DEB_LAST) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        if (state_nx != state || restart) begin
            cnt_nx = '0;
        end else if (cnt == CNT_MAX) begin
            cnt_nx = cnt;
        end else begin
            cnt_nx = cnt + CNT_W'(1);
        end

        pressed_nx = state_nx inside {HELD, REPEAT, REL_DEB};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            dec_pulse <= 1'b0;
            pressed   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            dec_pulse <= pulse_nx & en;
            pressed   <= pressed_nx;
        end
    end

    assign state_o = state;

endmodule
